div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_div_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit restoring divider controller for the EX stage.
// Three-state FSM (IDLE/CALC/DONE), one quotient bit per cycle, 32 steps,
// then one cycle to register the sign-corrected result.
// Optional feature: define DIV_RESULT_CACHE_EN to add a single-entry result
// cache that answers a repeated divide one cycle after start.
module div_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        div_en_i,
  input  logic        div_sign_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        div_ack_i,
  input  logic        flush_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        div_complete_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        fin_q;       // all 32 steps done, next CALC cycle registers the result
  logic        sign_q;
  logic        dvd_neg_q;
  logic        dvs_neg_q;
  logic [31:0] dvd_raw_q;   // kept for the divide-by-zero remainder
  logic [31:0] dvs_q;       // divisor magnitude
  logic [31:0] quo_q;       // dividend magnitude shifting out, quotient shifting in
  logic [31:0] rem_q;       // partial remainder
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;
  logic        complete_q;

  logic        start_neg_dvd, start_neg_dvs;
  logic [31:0] dvd_mag, dvs_mag;
  logic [32:0] shifted, diff;
  logic [31:0] rem_step, quo_step;
  logic [31:0] fin_quo, fin_rem;
  logic        hit_q;
  logic [31:0] cache_quo, cache_rem;
  logic        calc_finish;

  // Operand magnitudes and signs at start
  always_comb begin
    start_neg_dvd = div_sign_i & dividend_i[31];
    start_neg_dvs = div_sign_i & divisor_i[31];
    dvd_mag       = start_neg_dvd ? (~dividend_i + 32'd1) : dividend_i;
    dvs_mag       = start_neg_dvs ? (~divisor_i + 32'd1) : divisor_i;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    if (diff[32]) begin
      rem_step = shifted[31:0];
      quo_step = {quo_q[30:0], 1'b0};
    end else begin
      rem_step = diff[31:0];
      quo_step = {quo_q[30:0], 1'b1};
    end
  end

  // Final sign correction; divide-by-zero bypasses it entirely
  always_comb begin
    if (dvs_q == 32'd0) begin
      fin_quo = 32'hFFFF_FFFF;
      fin_rem = dvd_raw_q;
    end else begin
      fin_quo = (sign_q & (dvd_neg_q ^ dvs_neg_q)) ? (~quo_q + 32'd1) : quo_q;
      fin_rem = (sign_q & dvd_neg_q) ? (~rem_q + 32'd1) : rem_q;
    end
  end

  // A full computation completes this cycle (same priority as the FSM)
  assign calc_finish = (state_q == StCalc) & ~flush_i & div_en_i & fin_q & ~hit_q;

`ifdef DIV_RESULT_CACHE_EN
  logic        c_valid_q, c_sign_q;
  logic [31:0] c_dvd_q, c_dvs_q, c_quo_q, c_rem_q;
  logic [31:0] dvs_raw_q;
  logic        cache_hit;

  assign cache_hit = c_valid_q & (c_sign_q == div_sign_i) & (c_dvd_q == dividend_i) &
                     (c_dvs_q == divisor_i);
  assign cache_quo = c_quo_q;
  assign cache_rem = c_rem_q;

  // Single-entry result cache, written only on a completed computation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid_q <= 1'b0;
      c_sign_q  <= 1'b0;
      c_dvd_q   <= '0;
      c_dvs_q   <= '0;
      c_quo_q   <= '0;
      c_rem_q   <= '0;
      dvs_raw_q <= '0;
      hit_q     <= 1'b0;
    end else begin
      // Hit flag lives for the single CALC cycle that follows the start
      hit_q <= (state_q == StIdle) & div_en_i & ~flush_i & cache_hit;
      if ((state_q == StIdle) && div_en_i && !flush_i) begin
        dvs_raw_q <= divisor_i;
      end
      if (calc_finish) begin
        c_valid_q <= 1'b1;
        c_sign_q  <= sign_q;
        c_dvd_q   <= dvd_raw_q;
        c_dvs_q   <= dvs_raw_q;
        c_quo_q   <= fin_quo;
        c_rem_q   <= fin_rem;
      end
    end
  end
`else
  assign hit_q     = 1'b0;
  assign cache_quo = '0;
  assign cache_rem = '0;
`endif

  // Main FSM: flush beats everything, then per-state start/abort/step/ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
      sign_q      <= 1'b0;
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      dvd_raw_q   <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      complete_q  <= 1'b0;
    end else if (flush_i) begin
      state_q    <= StIdle;
      complete_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (div_en_i) begin
            state_q   <= StCalc;
            cnt_q     <= '0;
            fin_q     <= 1'b0;
            sign_q    <= div_sign_i;
            dvd_neg_q <= start_neg_dvd;
            dvs_neg_q <= start_neg_dvs;
            dvd_raw_q <= dividend_i;
            dvs_q     <= dvs_mag;
            quo_q     <= dvd_mag;
            rem_q     <= '0;
          end
        end
        StCalc: begin
          if (!div_en_i) begin
            state_q <= StIdle;
          end else if (hit_q) begin
            // Cached answer: skip the iterations
            state_q     <= StDone;
            complete_q  <= 1'b1;
            quotient_q  <= cache_quo;
            remainder_q <= cache_rem;
          end else if (fin_q) begin
            state_q     <= StDone;
            complete_q  <= 1'b1;
            quotient_q  <= fin_quo;
            remainder_q <= fin_rem;
          end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            if (cnt_q == 5'd31) begin
              fin_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        StDone: begin
          if (div_ack_i || !div_en_i) begin
            state_q    <= StIdle;
            complete_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          complete_q <= 1'b0;
        end
      endcase
    end
  end

  assign quotient_o     = quotient_q;
  assign remainder_o    = remainder_q;
  assign div_complete_o = complete_q;
  assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: table vectors, hand-written corner
// sequences and randomized divides against an arithmetic reference model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_en_i, div_sign_i, div_ack_i, flush_i;
  logic [31:0] dividend_i, divisor_i;
  logic [31:0] quotient_o, remainder_o;
  logic        div_complete_o, busy_o;

  int checks = 0;
  int errors = 0;

  // Reference model of the single-entry result cache
  logic        m_cv;
  logic        m_cs;
  logic [31:0] m_ca, m_cb;

  div_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .div_en_i       (div_en_i),
    .div_sign_i     (div_sign_i),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .div_ack_i      (div_ack_i),
    .flush_i        (flush_i),
    .quotient_o     (quotient_o),
    .remainder_o    (remainder_o),
    .div_complete_o (div_complete_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a, input logic [31:0] b, input logic sgn);
`ifdef DIV_RESULT_CACHE_EN
    return m_cv && m_cs == sgn && m_ca == a && m_cb == b;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one divide at a post-edge point; finish either by ack or by dropping
  // div_en. With keep_en the next call starts in the cycle after the ack.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [31:0] eq, input logic [31:0] er, input int ackdly,
                        input bit use_ack, input bit keep_en);
    int lat, exp_lat, hc;
    exp_lat = model_hit(a, b, sgn) ? 1 : 33;
    div_en_i   = 1'b1;
    div_sign_i = sgn;
    dividend_i = a;
    divisor_i  = b;
    div_ack_i  = 1'b0;
    @(posedge clk); #1;  // E0
    chk("busy_after_start", {31'd0, busy_o}, 32'd1);
    lat = 0;
    while (lat < 40 && !div_complete_o) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    if (div_complete_o) begin
      chk("quotient", quotient_o, eq);
      chk("remainder", remainder_o, er);
      m_cv = 1'b1; m_cs = sgn; m_ca = a; m_cb = b;
      hc = 1;
      for (int i = 0; i < ackdly; i++) begin
        @(posedge clk); #1;
        if (div_complete_o) hc++;
        chk("quotient_stable", quotient_o, eq);
        chk("remainder_stable", remainder_o, er);
      end
      if (use_ack) div_ack_i = 1'b1;
      else div_en_i = 1'b0;
      @(posedge clk); #1;
      div_ack_i = 1'b0;
      chk("complete_cycles", hc, ackdly + 1);
      chk("complete_low_after_end", {31'd0, div_complete_o}, 32'd0);
      chk("idle_after_end", {31'd0, busy_o}, 32'd0);
    end
    if (!keep_en) div_en_i = 1'b0;
  endtask

  // Start a divide and abandon it before completion
  task automatic start_only(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                            input int cyc);
    div_en_i   = 1'b1;
    div_sign_i = sgn;
    dividend_i = a;
    divisor_i  = b;
    @(posedge clk);  // E0
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic no_complete_for(input string name, input int cyc);
    int hi;
    hi = 0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
      if (div_complete_o) hi++;
    end
    chk(name, hi, 0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] a, b, eq, er;
    logic        sgn;
    int          hi;

    vecs[0] = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2};
    vecs[1] = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0};
    vecs[3] = '{32'h1234_5678, 32'd0,         1'b0, 32'hFFFF_FFFF, 32'h1234_5678};
    vecs[4] = '{32'hFFFF_FFF9, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    vecs[5] = '{32'hFFFF_FFFF, 32'd2,         1'b0, 32'h7FFF_FFFF, 32'd1};
    vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000};
    vecs[7] = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1};
    vecs[8] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,        32'hFFFF_FFFE};

    m_cv = 1'b0; m_cs = 1'b0; m_ca = '0; m_cb = '0;
    rst_n = 1'b0;
    div_en_i = 1'b0; div_sign_i = 1'b0; div_ack_i = 1'b0; flush_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    #1;
    chk("reset_complete", {31'd0, div_complete_o}, 32'd0);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_quotient", quotient_o, 32'd0);
    chk("reset_remainder", remainder_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors, ack on first complete cycle
    for (int i = 0; i < 9; i++) begin
      do_div(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].q, vecs[i].r, 0, 1'b1, 1'b0);
      @(posedge clk); #1;
    end

    // Repeat of the same divide (cache hit when enabled), then signed variant
    do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0, 1'b1, 1'b0);
    do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0, 1'b1, 1'b0);
    do_div(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 0, 1'b1, 1'b0);

    // Delayed ack, then back-to-back divide in the cycle after the ack
    do_div(32'd1000, 32'd9, 1'b0, 32'd111, 32'd1, 5, 1'b1, 1'b1);
    do_div(32'hFFFF_FC18, 32'd9, 1'b1, 32'hFFFF_FF91, 32'hFFFF_FFFF, 0, 1'b1, 1'b0);

    // Flush at cycle 10 of CALC; a new divide of the same operands runs full length
    start_only(32'd1000, 32'd3, 1'b0, 10);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    div_en_i = 1'b0;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_complete", {31'd0, div_complete_o}, 32'd0);
    no_complete_for("flush_no_complete", 2);
    do_div(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 0, 1'b1, 1'b0);

    // Flush wins over a simultaneous start
    div_en_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5; div_sign_i = 1'b0;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; div_en_i = 1'b0;
    chk("flush_over_start", {31'd0, busy_o}, 32'd0);

    // Cancel during CALC aborts and never completes
    start_only(32'd55, 32'd5, 1'b0, 5);
    div_en_i = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    no_complete_for("abort_no_complete", 40);
    do_div(32'd55, 32'd5, 1'b0, 32'd11, 32'd0, 0, 1'b1, 1'b0);

    // Cancel during DONE without ack
    do_div(32'd77, 32'd10, 1'b0, 32'd7, 32'd7, 2, 1'b0, 1'b0);

    // Randomized divides against the reference model
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 5) begin
        a = m_ca; b = m_cb; sgn = m_cs;
      end else begin
        a = $urandom;
        case ($urandom_range(0, 3))
          0: b = 32'd0;
          1: b = $urandom_range(1, 15);
          2: b = -$urandom_range(1, 15);
          default: b = $urandom;
        endcase
        sgn = $urandom_range(0, 1);
      end
      ref_div(a, b, sgn, eq, er);
      do_div(a, b, sgn, eq, er, $urandom_range(0, 3), 1'b1, 1'b0);
    end

    // Asynchronous reset mid-CALC
    start_only(32'd900, 32'd4, 1'b0, 10);
    #2;
    rst_n = 1'b0;
    div_en_i = 1'b0;
    m_cv = 1'b0;
    #1;
    chk("async_rst_calc_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_complete_for("rst_calc_no_complete", 40);

    // Asynchronous reset mid-DONE
    start_only(32'd900, 32'd4, 1'b0, 0);
    hi = 0;
    while (hi < 40 && !div_complete_o) begin
      @(posedge clk); #1;
      hi++;
    end
    chk("pre_reset_done", {31'd0, div_complete_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    div_en_i = 1'b0;
    m_cv = 1'b0;
    #1;
    chk("async_rst_done_complete", {31'd0, div_complete_o}, 32'd0);
    chk("async_rst_done_quotient", quotient_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_complete_for("rst_done_no_complete", 40);

    // After reset the cache (if any) is empty: full latency again
    @(posedge clk); #1;
    do_div(32'd900, 32'd4, 1'b0, 32'd225, 32'd0, 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
